// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch controller: state encoding,
// reset fetch address and the sequential PC increment.
package fetch_pkg;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_REQ  = 2'd1,
      ST_HOLD = 2'd2,
      ST_DROP = 2'd3
   } fetch_state_e;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam int unsigned PC_INC           = 32'd4;

   // A memory request is outstanding in both the live and the discarding state
   function automatic logic is_fetching(input fetch_state_e s);
      return (s == ST_REQ) || (s == ST_DROP);
   endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Bundle of the fetch controller's redirect, instruction-memory and decode
// handshakes; master is the fetch controller, slave is its environment.
interface fetch_ctrl_if #(
   parameter int N = 32
);
   logic         br_taken;
   logic [N-1:0] br_target;
   logic         id_ready;
   logic         imem_ack;
   logic [N-1:0] imem_rdata;
   logic         imem_req;
   logic [N-1:0] imem_addr;
   logic         if_valid;
   logic [N-1:0] if_pc;
   logic [N-1:0] if_inst;

   modport master (
      input  br_taken, br_target, id_ready, imem_ack, imem_rdata,
      output imem_req, imem_addr, if_valid, if_pc, if_inst
   );

   modport slave (
      output br_taken, br_target, id_ready, imem_ack, imem_rdata,
      input  imem_req, imem_addr, if_valid, if_pc, if_inst
   );
endinterface

// File: rtl/fetch_pc_reg.sv
// Fetch program-counter storage: N-bit register with load enable and
// asynchronous active-low reset to the boot address.
module fetch_pc_reg #(
   parameter int           N         = 32,
   parameter logic [N-1:0] RESET_VAL = {N{1'b0}}
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [N-1:0] d,
   output logic [N-1:0] q
);
   logic [N-1:0] pc_r;

   // PC holds its value unless the controller commits a new fetch address
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_r <= RESET_VAL;
      end else if (load) begin
         pc_r <= d;
      end
   end

   assign q = pc_r;
endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues one word fetch at a time, buffers the
// returned instruction for decode and handles branch redirects.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int           N        = 32,
   parameter logic [N-1:0] RESET_PC = N'(RESET_PC_DEFAULT)
) (
   input  logic         clk,
   input  logic         rst,
   fetch_ctrl_if.master bus
);
   fetch_state_e state_r;
   fetch_state_e state_next_s;

   logic [N-1:0] pc_q_s;
   logic [N-1:0] pc_d_s;
   logic [N-1:0] pc_next_s;
   logic         pc_load_s;
   logic [N-1:0] target_s;
   logic         capture_s;

   logic         req_r;
   logic [N-1:0] addr_r;
   logic         if_valid_r;
   logic [N-1:0] if_pc_r;
   logic [N-1:0] if_inst_r;

   logic         unused_br_low_s;

   // Redirect targets are forced to a word boundary
   assign target_s        = {bus.br_target[N-1:2], 2'b00};
   assign unused_br_low_s = ^bus.br_target[1:0];

   fetch_pc_reg #(
      .N         (N),
      .RESET_VAL (RESET_PC)
   ) u_pc (
      .clk  (clk),
      .rst  (rst),
      .load (pc_load_s),
      .d    (pc_d_s),
      .q    (pc_q_s)
   );

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= ST_BOOT;
      end else begin
         state_r <= state_next_s;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_BOOT: begin
            state_next_s = ST_REQ;
         end
         ST_REQ: begin
            if (bus.br_taken && !bus.imem_ack) begin
               state_next_s = ST_DROP;
            end else if (bus.br_taken) begin
               state_next_s = ST_REQ;
            end else if (bus.imem_ack) begin
               state_next_s = ST_HOLD;
            end else begin
               state_next_s = ST_REQ;
            end
         end
         ST_HOLD: begin
            if (bus.br_taken || bus.id_ready) begin
               state_next_s = ST_REQ;
            end else begin
               state_next_s = ST_HOLD;
            end
         end
         ST_DROP: begin
            if (bus.imem_ack) begin
               state_next_s = ST_REQ;
            end else begin
               state_next_s = ST_DROP;
            end
         end
         default: begin
            state_next_s = ST_BOOT;
         end
      endcase
   end

   // FSM output decode: PC update select and instruction capture strobe
   always_comb begin
      pc_load_s = 1'b0;
      pc_d_s    = pc_q_s;
      capture_s = 1'b0;
      if (bus.br_taken) begin
         pc_load_s = 1'b1;
         pc_d_s    = target_s;
      end else if ((state_r == ST_REQ) && bus.imem_ack) begin
         pc_load_s = 1'b1;
         pc_d_s    = pc_q_s + N'(PC_INC);
         capture_s = 1'b1;
      end else begin
         pc_load_s = 1'b0;
         pc_d_s    = pc_q_s;
      end
   end

   assign pc_next_s = pc_load_s ? pc_d_s : pc_q_s;

   // Output registers; the discarding state keeps presenting the stale address
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         req_r      <= 1'b0;
         addr_r     <= RESET_PC;
         if_valid_r <= 1'b0;
         if_pc_r    <= {N{1'b0}};
         if_inst_r  <= {N{1'b0}};
      end else begin
         req_r      <= is_fetching(state_next_s);
         addr_r     <= (state_next_s == ST_DROP) ? addr_r : pc_next_s;
         if_valid_r <= (state_next_s == ST_HOLD);
         if (capture_s) begin
            if_pc_r   <= pc_q_s;
            if_inst_r <= bus.imem_rdata;
         end
      end
   end

   assign bus.imem_req  = req_r;
   assign bus.imem_addr = addr_r;
   assign bus.if_valid  = if_valid_r;
   assign bus.if_pc     = if_pc_r;
   assign bus.if_inst   = if_inst_r;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a transaction-level model.
module tb_fetch_ctrl;
   localparam int N = 32;

   logic         clk;
   logic         rst;
   logic         br;
   logic [N-1:0] bt;
   logic         ack;
   logic [N-1:0] rdata;
   logic         idr;
   logic         chk_en;

   int n_checks;
   int n_err;

   // Model: outstanding request, its fate, and the instruction handed to decode
   logic [N-1:0] m_pc;
   logic         m_boot;
   logic         m_req;
   logic [N-1:0] m_addr;
   logic         m_discard;
   logic         m_valid;
   logic [N-1:0] m_if_pc;
   logic [N-1:0] m_if_inst;

   fetch_ctrl_if #(.N(N)) bus ();

   assign bus.br_taken   = br;
   assign bus.br_target  = bt;
   assign bus.imem_ack   = ack;
   assign bus.imem_rdata = rdata;
   assign bus.id_ready   = idr;

   fetch_ctrl #(.N(N), .RESET_PC(32'h0000_0000)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc      = 32'h0000_0000;
      m_boot    = 1'b1;
      m_req     = 1'b0;
      m_addr    = 32'h0000_0000;
      m_discard = 1'b0;
      m_valid   = 1'b0;
      m_if_pc   = 32'h0000_0000;
      m_if_inst = 32'h0000_0000;
   endtask

   task automatic model_step();
      logic [N-1:0] tgt;
      tgt = bt & 32'hFFFF_FFFC;
      if (m_boot) begin
         m_boot = 1'b0;
         if (br) m_pc = tgt;
         m_req     = 1'b1;
         m_addr    = m_pc;
         m_discard = 1'b0;
      end else if (m_req) begin
         if (ack) begin
            if (!m_discard && !br) begin
               m_valid   = 1'b1;
               m_if_pc   = m_addr;
               m_if_inst = rdata;
               m_pc      = m_addr + 32'd4;
               m_req     = 1'b0;
               m_addr    = m_pc;
            end else begin
               if (br) m_pc = tgt;
               m_req     = 1'b1;
               m_addr    = m_pc;
               m_discard = 1'b0;
            end
         end else if (br) begin
            m_pc      = tgt;
            m_discard = 1'b1;
         end
      end else begin
         if (br) m_pc = tgt;
         if (br || idr) begin
            m_valid = 1'b0;
            m_req   = 1'b1;
            m_addr  = m_pc;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) model_step();
      #2;
   endtask

   // Per-cycle comparison of the DUT against the model
   always @(negedge clk) begin
      if (chk_en) begin
         check("imem_req", {31'd0, bus.imem_req}, {31'd0, m_req});
         if (m_req) check("imem_addr", bus.imem_addr, m_addr);
         check("if_valid", {31'd0, bus.if_valid}, {31'd0, m_valid});
         if (m_valid) begin
            check("if_pc", bus.if_pc, m_if_pc);
            check("if_inst", bus.if_inst, m_if_inst);
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req"},   {31'd0, bus.imem_req}, 32'd0);
      check({tag, "_addr"},  bus.imem_addr, 32'h0000_0000);
      check({tag, "_valid"}, {31'd0, bus.if_valid}, 32'd0);
      check({tag, "_pc"},    bus.if_pc, 32'h0000_0000);
      check({tag, "_inst"},  bus.if_inst, 32'h0000_0000);
   endtask

   initial begin
      logic [N-1:0] addr_q[$];
      logic [N-1:0] ifpc_q[$];
      n_checks = 0;
      n_err    = 0;
      chk_en   = 1'b0;
      br = 1'b0; bt = 32'd0; ack = 1'b0; rdata = 32'd0; idr = 1'b0;
      rst = 1'b1;
      #1 rst = 1'b0;
      model_reset();
      #1 chk_en = 1'b1;
      #1 check_reset_outputs("reset");

      // Back-to-back fetches with memory and decode always ready
      ack = 1'b1; idr = 1'b1;
      tick();
      rst = 1'b1;
      for (int i = 0; i < 6; i++) begin
         rdata = $urandom;
         tick();
         if (bus.imem_req) addr_q.push_back(bus.imem_addr);
         if (bus.if_valid) ifpc_q.push_back(bus.if_pc);
      end
      check("seq_len", addr_q.size(), 32'd3);
      if (addr_q.size() >= 3) begin
         check("seq_a0", addr_q[0], 32'h0);
         check("seq_a1", addr_q[1], 32'h4);
         check("seq_a2", addr_q[2], 32'h8);
      end
      check("seq_pc_len", ifpc_q.size(), 32'd3);
      if (ifpc_q.size() >= 2) begin
         check("seq_pc0", ifpc_q[0], 32'h0);
         check("seq_pc1", ifpc_q[1], 32'h4);
      end

      // Slow memory: request at 0x10 held until the ack in its 4th cycle
      br = 1'b1; bt = 32'h10; ack = 1'b0; idr = 1'b0;
      tick();
      br = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("slow_req", {31'd0, bus.imem_req}, 32'd1);
         check("slow_addr", bus.imem_addr, 32'h10);
         ack = (i == 3); rdata = 32'hCAFE_0010;
         tick();
      end
      check("slow_valid", {31'd0, bus.if_valid}, 32'd1);
      check("slow_inst", bus.if_inst, 32'hCAFE_0010);
      check("slow_pc", bus.if_pc, 32'h10);

      // Redirect while a request at 0x20 is pending
      br = 1'b1; bt = 32'h20; ack = 1'b0;
      tick();
      check("drop_pend", bus.imem_addr, 32'h20);
      bt = 32'h103;
      tick();
      check("drop_stale_addr", bus.imem_addr, 32'h20);
      check("drop_req", {31'd0, bus.imem_req}, 32'd1);
      br = 1'b0; ack = 1'b1; rdata = 32'hDEAD_BEEF;
      tick();
      check("drop_valid0", {31'd0, bus.if_valid}, 32'd0);
      check("drop_new_addr", bus.imem_addr, 32'h100);
      ack = 1'b0;
      tick();
      check("drop_valid1", {31'd0, bus.if_valid}, 32'd0);
      ack = 1'b1; rdata = 32'h1234_5678;
      tick();
      check("drop_valid2", {31'd0, bus.if_valid}, 32'd1);
      check("drop_pc", bus.if_pc, 32'h100);
      check("drop_inst", bus.if_inst, 32'h1234_5678);

      // Decode stalls for 5 cycles, then a redirect flushes the buffer
      ack = 1'b0; idr = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("stall_valid", {31'd0, bus.if_valid}, 32'd1);
         check("stall_pc", bus.if_pc, 32'h100);
      end
      br = 1'b1; bt = 32'h40;
      tick();
      check("flush_valid", {31'd0, bus.if_valid}, 32'd0);
      check("flush_addr", bus.imem_addr, 32'h40);

      // Wrap from the top of the address space
      bt = 32'hFFFF_FFFE; ack = 1'b1;
      tick();
      check("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);
      check("wrap_valid0", {31'd0, bus.if_valid}, 32'd0);
      br = 1'b0; idr = 1'b1; rdata = $urandom;
      tick();
      check("wrap_pc", bus.if_pc, 32'hFFFF_FFFC);
      tick();
      check("wrap_next", bus.imem_addr, 32'h0000_0000);
      check("wrap_req", {31'd0, bus.imem_req}, 32'd1);

      // Reset in the middle of a pending request, late ack after release
      br = 1'b1; bt = 32'h80;
      tick();
      br = 1'b0; ack = 1'b0;
      tick();
      check("mid_addr", bus.imem_addr, 32'h80);
      rst = 1'b0;
      model_reset();
      #1 check_reset_outputs("midrst");
      ack = 1'b1; idr = 1'b1;
      tick();
      rst = 1'b1;
      tick();
      check("boot_req", {31'd0, bus.imem_req}, 32'd1);
      check("boot_addr", bus.imem_addr, 32'h0);
      check("boot_valid", {31'd0, bus.if_valid}, 32'd0);
      tick();
      check("boot_fetch", {31'd0, bus.if_valid}, 32'd1);
      check("boot_pc", bus.if_pc, 32'h0);

      // Randomized traffic against the model
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 249) == 0) begin
            rst = 1'b0;
            model_reset();
            ack = $urandom_range(0, 1);
            tick();
            rst = 1'b1;
         end else begin
            br    = ($urandom_range(0, 7) == 0);
            bt    = $urandom;
            if ($urandom_range(0, 15) == 0) bt = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
            ack   = $urandom_range(0, 1);
            idr   = $urandom_range(0, 1);
            rdata = $urandom;
            tick();
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
